fft_mem_pingpong: RTL and testbench

//  Parametrised NxN transpose memory for the base-N 2-D FFT (N = 2**SIZE_MAT_WD), double-buffered.

---
 rtl/fft_mem_pingpong_pkg.sv | 12 +
 rtl/fft_mem_pingpong_bank.sv | 58 +++++
 rtl/fft_mem_pingpong.sv | 132 +++++++++++++
 tb/tb_fft_mem_pingpong.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_mem_pingpong_pkg.sv
// rtl/fft_mem_pingpong_pkg.sv - shared defaults and dimension codes for the transpose memory
package fft_mem_pingpong_pkg;

  localparam int DATA_WD_DEF     = 20;
  localparam int SIZE_MAT_WD_DEF = 3;

  typedef enum logic {
    DIM_ROW = 1'b0,
    DIM_COL = 1'b1
  } dim_e;

endpackage

// File: rtl/fft_mem_pingpong_bank.sv
// rtl/fft_mem_pingpong_bank.sv - one NxN bank with row/col 1xN and 1x1 access
module fft_mem_pingpong_bank
  import fft_mem_pingpong_pkg::*;
#(
  parameter int                 DATA_WD     = DATA_WD_DEF,
  parameter int                 SIZE_MAT_WD = SIZE_MAT_WD_DEF,
  parameter logic [DATA_WD-1:0] RST_VAL     = DATA_WD'('hfffff)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      wr_en,
  input  logic                                      wr_dim,
  input  logic [SIZE_MAT_WD-1:0]                    wr_addr,
  input  logic [(1<<SIZE_MAT_WD)*DATA_WD-1:0]       wr_dat,
  input  logic                                      wr1_en,
  input  logic [2*SIZE_MAT_WD-1:0]                  wr1_addr,
  input  logic [DATA_WD-1:0]                        wr1_dat,
  input  logic                                      rd_dim,
  input  logic [SIZE_MAT_WD-1:0]                    rd_addr,
  output logic [(1<<SIZE_MAT_WD)*DATA_WD-1:0]       rd_dat,
  input  logic [2*SIZE_MAT_WD-1:0]                  rd1_addr,
  output logic [DATA_WD-1:0]                        rd1_dat
);

  localparam int N     = 1 << SIZE_MAT_WD;
  localparam int CELLS = N * N;

  // linear address row*N+col is simply {row, col}
  logic [DATA_WD-1:0] cells [CELLS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) cells[i] <= RST_VAL;
    end else if (wr1_en) begin
      cells[wr1_addr] <= wr1_dat;
    end else if (wr_en) begin
      for (int k = 0; k < N; k++) begin
        if (wr_dim == DIM_COL)
          cells[{SIZE_MAT_WD'(k), wr_addr}] <= wr_dat[k*DATA_WD +: DATA_WD];
        else
          cells[{wr_addr, SIZE_MAT_WD'(k)}] <= wr_dat[k*DATA_WD +: DATA_WD];
      end
    end
  end

  always_comb begin
    rd_dat = '0;
    for (int k = 0; k < N; k++) begin
      if (rd_dim == DIM_COL)
        rd_dat[k*DATA_WD +: DATA_WD] = cells[{SIZE_MAT_WD'(k), rd_addr}];
      else
        rd_dat[k*DATA_WD +: DATA_WD] = cells[{rd_addr, SIZE_MAT_WD'(k)}];
    end
  end

  assign rd1_dat = cells[rd1_addr];

endmodule

// File: rtl/fft_mem_pingpong.sv
// rtl/fft_mem_pingpong.sv - double-buffered NxN transpose memory with done-handshake bank swap
module fft_mem_pingpong
  import fft_mem_pingpong_pkg::*;
#(
  parameter int                 DATA_WD     = DATA_WD_DEF,
  parameter int                 SIZE_MAT_WD = SIZE_MAT_WD_DEF,
  parameter logic [DATA_WD-1:0] RST_VAL     = DATA_WD'('hfffff)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_vld_i,
  input  logic                                wr_dim_i,
  input  logic [SIZE_MAT_WD-1:0]              wr_addr_i,
  input  logic [(1<<SIZE_MAT_WD)*DATA_WD-1:0] wr_dat_i,
  input  logic                                wr1_vld_i,
  input  logic [2*SIZE_MAT_WD-1:0]            wr1_addr_i,
  input  logic [DATA_WD-1:0]                  wr1_dat_i,
  input  logic                                wr_done_i,
  output logic                                wr_rdy_o,
  input  logic                                rd_vld_i,
  input  logic                                rd_dim_i,
  input  logic [SIZE_MAT_WD-1:0]              rd_addr_i,
  output logic                                rd_vld_o,
  output logic [(1<<SIZE_MAT_WD)*DATA_WD-1:0] rd_dat_o,
  input  logic                                rd1_vld_i,
  input  logic [2*SIZE_MAT_WD-1:0]            rd1_addr_i,
  output logic                                rd1_vld_o,
  output logic [DATA_WD-1:0]                  rd1_dat_o,
  input  logic                                rd_done_i,
  output logic                                rd_rdy_o,
  output logic                                err_o
);

  localparam int N  = 1 << SIZE_MAT_WD;
  localparam int LW = N * DATA_WD;

  // reset asserts asynchronously, releases two clocks later in this domain
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  logic       wp;
  logic       rp;
  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       wr_rdy;
  logic       rd_rdy;
  logic       wr_go;
  logic       wr1_go;
  logic       wr_swap;
  logic       rd_swap;
  logic       rd_go;
  logic       rd1_go;
  logic       err_set;

  logic [LW-1:0]      bank_rd_dat  [2];
  logic [DATA_WD-1:0] bank_rd1_dat [2];

  assign wr_rdy   = !full[wp];
  assign rd_rdy   = full[rp];
  assign wr_rdy_o = wr_rdy;
  assign rd_rdy_o = rd_rdy;

  // a 1x1 write in the same cycle drops the 1xN write completely
  assign wr1_go  = wr1_vld_i & wr_rdy;
  assign wr_go   = wr_vld_i & ~wr1_vld_i & wr_rdy;
  assign rd_go   = rd_vld_i & rd_rdy;
  assign rd1_go  = rd1_vld_i & rd_rdy;
  assign wr_swap = wr_done_i & wr_rdy;
  assign rd_swap = rd_done_i & rd_rdy;
  assign err_set = ((wr_vld_i | wr1_vld_i | wr_done_i) & ~wr_rdy) |
                   ((rd_vld_i | rd1_vld_i | rd_done_i) & ~rd_rdy);

  // wr_rdy needs full[wp]=0 and rd_rdy needs full[rp]=1, so both swaps always hit different banks
  always_comb begin
    full_nxt = full;
    if (wr_swap) full_nxt[wp] = 1'b1;
    if (rd_swap) full_nxt[rp] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wp        <= 1'b0;
      rp        <= 1'b0;
      full      <= 2'b00;
      err_o     <= 1'b0;
      rd_vld_o  <= 1'b0;
      rd1_vld_o <= 1'b0;
      rd_dat_o  <= '0;
      rd1_dat_o <= '0;
    end else begin
      wp        <= wp ^ wr_swap;
      rp        <= rp ^ rd_swap;
      full      <= full_nxt;
      err_o     <= err_o | err_set;
      rd_vld_o  <= rd_go;
      rd1_vld_o <= rd1_go;
      if (rd_go)  rd_dat_o  <= bank_rd_dat[rp];
      if (rd1_go) rd1_dat_o <= bank_rd1_dat[rp];
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_mem_pingpong_bank #(
      .DATA_WD     (DATA_WD),
      .SIZE_MAT_WD (SIZE_MAT_WD),
      .RST_VAL     (RST_VAL)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_int_n),
      .wr_en    (wr_go  & (wp == 1'(b))),
      .wr_dim   (wr_dim_i),
      .wr_addr  (wr_addr_i),
      .wr_dat   (wr_dat_i),
      .wr1_en   (wr1_go & (wp == 1'(b))),
      .wr1_addr (wr1_addr_i),
      .wr1_dat  (wr1_dat_i),
      .rd_dim   (rd_dim_i),
      .rd_addr  (rd_addr_i),
      .rd_dat   (bank_rd_dat[b]),
      .rd1_addr (rd1_addr_i),
      .rd1_dat  (bank_rd1_dat[b])
    );
  end

endmodule

// File: tb/tb_fft_mem_pingpong.sv
// tb/tb_fft_mem_pingpong.sv - randomized and directed checks of fft_mem_pingpong against a frame-queue model
module tb_fft_mem_pingpong;

  localparam int DW = 20;
  localparam int SW = 3;
  localparam int N  = 8;
  localparam int C  = 64;
  localparam int W  = N * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_vld_i, wr_dim_i, wr1_vld_i, wr_done_i;
  logic [SW-1:0] wr_addr_i;
  logic [W-1:0]  wr_dat_i;
  logic [2*SW-1:0] wr1_addr_i;
  logic [DW-1:0] wr1_dat_i;
  logic          wr_rdy_o;
  logic          rd_vld_i, rd_dim_i, rd1_vld_i, rd_done_i;
  logic [SW-1:0] rd_addr_i;
  logic [2*SW-1:0] rd1_addr_i;
  logic          rd_vld_o, rd1_vld_o, rd_rdy_o, err_o;
  logic [W-1:0]  rd_dat_o;
  logic [DW-1:0] rd1_dat_o;

  always #5 clk = ~clk;

  fft_mem_pingpong dut (
    .clk(clk), .rst_n(rst_n),
    .wr_vld_i(wr_vld_i), .wr_dim_i(wr_dim_i), .wr_addr_i(wr_addr_i), .wr_dat_i(wr_dat_i),
    .wr1_vld_i(wr1_vld_i), .wr1_addr_i(wr1_addr_i), .wr1_dat_i(wr1_dat_i),
    .wr_done_i(wr_done_i), .wr_rdy_o(wr_rdy_o),
    .rd_vld_i(rd_vld_i), .rd_dim_i(rd_dim_i), .rd_addr_i(rd_addr_i),
    .rd_vld_o(rd_vld_o), .rd_dat_o(rd_dat_o),
    .rd1_vld_i(rd1_vld_i), .rd1_addr_i(rd1_addr_i),
    .rd1_vld_o(rd1_vld_o), .rd1_dat_o(rd1_dat_o),
    .rd_done_i(rd_done_i), .rd_rdy_o(rd_rdy_o), .err_o(err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // frames form a depth-2 queue: writer fills frame (#wr_dones mod 2), reader drains (#rd_dones mod 2)
  logic [DW-1:0] mem [2][C];
  int            nfull, wb, rb;
  logic          err_m, e_vld, e1_vld;
  logic [W-1:0]  e_dat;
  logic [DW-1:0] e1_dat;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pat(input int base, input int stride);
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(base + k*stride);
    return v;
  endfunction

  function automatic logic [W-1:0] gather(input int b, input logic dim, input int a);
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = dim ? mem[b][k*N+a] : mem[b][a*N+k];
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < C; i++) mem[b][i] = 20'hfffff;
    nfull = 0; wb = 0; rb = 0;
    err_m = 1'b0; e_vld = 1'b0; e1_vld = 1'b0; e_dat = '0; e1_dat = '0;
  endtask

  task automatic idle();
    wr_vld_i = 0; wr_dim_i = 0; wr_addr_i = '0; wr_dat_i = '0;
    wr1_vld_i = 0; wr1_addr_i = '0; wr1_dat_i = '0; wr_done_i = 0;
    rd_vld_i = 0; rd_dim_i = 0; rd_addr_i = '0; rd1_vld_i = 0; rd1_addr_i = '0; rd_done_i = 0;
  endtask

  task automatic check_all();
    check_eq("wr_rdy",   W'(wr_rdy_o),  W'(nfull < 2));
    check_eq("rd_rdy",   W'(rd_rdy_o),  W'(nfull > 0));
    check_eq("err",      W'(err_o),     W'(err_m));
    check_eq("rd_vld",   W'(rd_vld_o),  W'(e_vld));
    check_eq("rd1_vld",  W'(rd1_vld_o), W'(e1_vld));
    check_eq("rd_dat",   rd_dat_o,      e_dat);
    check_eq("rd1_dat",  W'(rd1_dat_o), W'(e1_dat));
  endtask

  task automatic step();
    bit wok, rok;
    wok = (nfull < 2);
    rok = (nfull > 0);
    if ((wr_vld_i || wr1_vld_i || wr_done_i) && !wok) err_m = 1'b1;
    if ((rd_vld_i || rd1_vld_i || rd_done_i) && !rok) err_m = 1'b1;
    e_vld  = rd_vld_i && rok;
    e1_vld = rd1_vld_i && rok;
    if (e_vld)  e_dat  = gather(rb, rd_dim_i, int'(rd_addr_i));
    if (e1_vld) e1_dat = mem[rb][int'(rd1_addr_i)];
    if (wok) begin
      if (wr1_vld_i) mem[wb][int'(wr1_addr_i)] = wr1_dat_i;
      else if (wr_vld_i)
        for (int k = 0; k < N; k++) begin
          if (wr_dim_i) mem[wb][k*N + int'(wr_addr_i)] = wr_dat_i[k*DW +: DW];
          else          mem[wb][int'(wr_addr_i)*N + k] = wr_dat_i[k*DW +: DW];
        end
    end
    if (wr_done_i && wok) begin wb ^= 1; nfull++; end
    if (rd_done_i && rok) begin rb ^= 1; nfull--; end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic do_wr(input logic dim, input int a, input logic [W-1:0] d);
    idle(); wr_vld_i = 1; wr_dim_i = dim; wr_addr_i = SW'(a); wr_dat_i = d; step(); idle();
  endtask

  task automatic do_rd(input logic dim, input int a);
    idle(); rd_vld_i = 1; rd_dim_i = dim; rd_addr_i = SW'(a); step(); idle();
  endtask

  task automatic do_rd1(input int a);
    idle(); rd1_vld_i = 1; rd1_addr_i = (2*SW)'(a); step(); idle();
  endtask

  task automatic do_done(input logic w, input logic r);
    idle(); wr_done_i = w; rd_done_i = r; step(); idle();
  endtask

  logic [W-1:0] exp_v;

  initial begin
    idle();
    rst_n = 1'b0;
    apply_reset();
    check_eq("rst_wr_rdy", W'(wr_rdy_o), W'(1'b1));
    check_eq("rst_rd_rdy", W'(rd_rdy_o), W'(1'b0));
    check_eq("rst_err",    W'(err_o),    W'(1'b0));

    // partial frame: unwritten cell still holds reset value
    do_wr(1'b0, 0, pat(0, 1));
    do_done(1'b1, 1'b0);
    do_rd1(63);
    check_eq("unwritten_cell", W'(rd1_dat_o), W'(20'hfffff));
    do_rd1(2);
    check_eq("written_cell", W'(rd1_dat_o), W'(20'd2));
    do_done(1'b0, 1'b1);

    // full row fill, then transposed column read
    for (int r = 0; r < N; r++) do_wr(1'b0, r, pat(r*N, 1));
    do_done(1'b1, 1'b0);
    check_eq("rdy_after_done", W'(rd_rdy_o), W'(1'b1));
    do_rd(1'b1, 3);
    check_eq("col3_vld", W'(rd_vld_o), W'(1'b1));
    check_eq("col3_dat", rd_dat_o, pat(3, N));

    // ping-pong: write other bank while reading, then both dones together
    for (int r = 0; r < N; r++) begin
      idle();
      wr_vld_i = 1; wr_dim_i = 1'($urandom); wr_addr_i = SW'(r);
      for (int k = 0; k < N; k++) wr_dat_i[k*DW +: DW] = DW'($urandom);
      rd_vld_i = 1; rd_dim_i = 1'($urandom); rd_addr_i = SW'(r);
      rd1_vld_i = 1; rd1_addr_i = (2*SW)'($urandom);
      step();
    end
    do_done(1'b1, 1'b1);
    check_eq("swap_wr_rdy", W'(wr_rdy_o), W'(1'b1));
    check_eq("swap_rd_rdy", W'(rd_rdy_o), W'(1'b1));
    for (int r = 0; r < N; r++) do_rd(1'b0, r);

    // 1x1 write wins over a simultaneous 1xN write into the bank holding the row-fill data
    idle();
    wr1_vld_i = 1; wr1_addr_i = 6'd10; wr1_dat_i = 20'h12345;
    wr_vld_i = 1; wr_dim_i = 1'b0; wr_addr_i = 3'd1; wr_dat_i = pat(20'h55000, 3);
    step();
    do_done(1'b1, 1'b1);
    do_rd(1'b0, 1);
    exp_v = pat(N, 1);
    exp_v[2*DW +: DW] = 20'h12345;
    check_eq("wr1_priority", rd_dat_o, exp_v);

    // both banks full: write is a violation
    do_done(1'b1, 1'b0);
    check_eq("full_wr_rdy", W'(wr_rdy_o), W'(1'b0));
    do_wr(1'b0, 2, pat(7, 7));
    check_eq("full_err", W'(err_o), W'(1'b1));
    check_eq("full_wr_rdy_hold", W'(wr_rdy_o), W'(1'b0));
    do_done(1'b0, 1'b1);
    do_done(1'b0, 1'b1);
    do_rd(1'b0, 0);
    check_eq("empty_rd_vld", W'(rd_vld_o), W'(1'b0));

    // reset in the middle of a read burst
    do_wr(1'b1, 5, pat(100, 9));
    do_done(1'b1, 1'b0);
    idle(); rd_vld_i = 1; rd_addr_i = 3'd5; rd_dim_i = 1'b1; step();
    apply_reset();
    do_done(1'b1, 1'b0);
    do_rd1(int'($urandom_range(0, C-1)));
    check_eq("post_reset_cell", W'(rd1_dat_o), W'(20'hfffff));
    do_done(1'b0, 1'b1);

    // randomized traffic, protocol violations only late in the run
    for (int c = 0; c < 3000; c++) begin
      bit viol, wok, rok;
      viol = (c > 2000) && ($urandom_range(0, 19) == 0);
      wok  = (nfull < 2) || viol;
      rok  = (nfull > 0) || viol;
      idle();
      wr_vld_i   = wok && ($urandom_range(0, 2) == 0);
      wr_dim_i   = 1'($urandom);
      wr_addr_i  = SW'($urandom);
      for (int k = 0; k < N; k++) wr_dat_i[k*DW +: DW] = DW'($urandom);
      wr1_vld_i  = wok && ($urandom_range(0, 4) == 0);
      wr1_addr_i = (2*SW)'($urandom);
      wr1_dat_i  = DW'($urandom);
      wr_done_i  = wok && ($urandom_range(0, 9) == 0);
      rd_vld_i   = rok && ($urandom_range(0, 1) == 0);
      rd_dim_i   = 1'($urandom);
      rd_addr_i  = SW'($urandom);
      rd1_vld_i  = rok && ($urandom_range(0, 2) == 0);
      rd1_addr_i = (2*SW)'($urandom);
      rd_done_i  = rok && ($urandom_range(0, 9) == 0);
      step();
      if (c == 1500) apply_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
